// File: rtl/piso_serializer.sv
// Parallel-in serial-out stage: captures a word on a load request and shifts it
// out one bit per clock, flagging completion and any load dropped mid-frame.
module piso_serializer #(
    parameter int N         = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic         C,
    input  logic         R,
    input  logic [N-1:0] in,
    input  logic         L,
    output logic         so,
    output logic         busy,
    output logic         done,
    output logic         lost
);

    localparam int             CW   = $clog2(N) + 1;
    localparam logic [CW-1:0]  LAST = CW'(N);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t         state;
    logic [N-1:0]   shreg;
    logic [CW-1:0]  count;

    logic           first_bit;
    logic           next_bit;
    logic [N-1:0]   shifted;

    // The bit about to leave always sits next to the one just sent, so the
    // register advances toward whichever end is sent first.
    assign first_bit = MSB_FIRST ? in[N-1]    : in[0];
    assign next_bit  = MSB_FIRST ? shreg[N-2] : shreg[1];
    assign shifted   = MSB_FIRST ? (shreg << 1) : (shreg >> 1);

    // NOTE: all state and outputs update with non-blocking assignments so every
    // register samples pre-edge values; blocking here would create ordering races.
    always_ff @(posedge C) begin
        if (R) begin
            state <= IDLE;
            shreg <= '0;
            count <= '0;
            so    <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            lost  <= 1'b0;
        end else begin
            done <= 1'b0;
            lost <= 1'b0;
            unique case (state)
                IDLE: begin
                    so <= 1'b0;
                    if (L) begin
                        shreg <= in;
                        so    <= first_bit;
                        busy  <= 1'b1;
                        count <= CW'(1);
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    // A load during a frame never touches the word in flight.
                    lost <= L;
                    if (count == LAST) begin
                        so    <= 1'b0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end else begin
                        so    <= next_bit;
                        shreg <= shifted;
                        count <= count + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
Parallel-in serial-out stage placed directly downstream of the controlled 8-bit buffer register. It captures the register's parallel output word on a load request and shifts it out one bit per clock on a single serial line. It reports busy and completion status. A load request that arrives while a word is still shifting is dropped and flagged, so the producer can tell that data was lost.

Parameters:
N, 8, word width in bits (N >= 2)
MSB_FIRST, 1, 1 = shift in[N-1] first, 0 = shift in[0] first

Ports:
C  input  1  clock; all state updates on posedge C
R  input  1  synchronous reset, active-high
in  input  N  parallel word from the buffer register output
L  input  1  load request, sampled on posedge C
so  output  1  serial data out
busy  output  1  high while a word is being shifted
done  output  1  one-cycle pulse after the last bit of a word
lost  output  1  one-cycle pulse per edge where L=1 is rejected

Behaviour:
- Reset: R=1 at posedge C forces these values. R has priority over every other input.
  - state=IDLE, shreg=0, count=0
  - so=0, busy=0, done=0, lost=0
- Internal state:
  - shreg: N-bit shift register.
  - count: counter of width $clog2(N)+1.
  - FSM: two states, IDLE and SHIFT. All outputs are registered.
- IDLE:
  - done and lost default to 0 each edge unless set below. so=0.
  - If L=1 at an edge (edge E0):
    - shreg <= in and the first bit is driven: so <= in[N-1] if MSB_FIRST=1, else in[0].
    - busy <= 1, count <= 1, state <= SHIFT.
- SHIFT:
  - Edges E1..E(N-1): so <= next bit in order (MSB toward LSB, or LSB toward MSB). count increments.
  - Edge EN (count==N):
    - so <= 0, busy <= 0, done <= 1, state <= IDLE.
- Latency and timing:
  - Bit k of the word (k=0..N-1 in shift order) is valid on so for the cycle after edge Ek.
  - The whole frame is busy for N cycles. done rises after EN and lasts exactly one cycle.
- Rejected loads:
  - L=1 at any edge while state=SHIFT (including EN) is ignored and sets lost <= 1 for one cycle.
  - shreg, so and count are unaffected by a rejected load.
  - L held high through a frame gives lost=1 every cycle of that frame.
- Back-to-back frames:
  - Earliest accepted next load is edge E(N+1), the first edge in IDLE.
  - Minimum frame spacing is N+1 cycles.
  - done=1 and a new load can coincide at E(N+1): the load is accepted and done clears on the next edge.
- Input timing:
  - in is sampled only at the accepting edge. Later changes to in never alter a word in flight.
- Reset mid-frame: R=1 aborts the frame immediately.
  - All outputs return to reset values on that edge.
  - No done pulse is generated.
  - The next L=1 with R=0 starts a fresh frame.
- L while idle with no change on in: a new frame of the same word is sent. There is no duplicate suppression.

Test Plan:
- Reset check: R=1 for 2 edges, then R=0 with L=0 -> so=0, busy=0, done=0, lost=0 held.
- MSB-first frame: N=8, MSB_FIRST=1, in=8'b10110011, L=1 for one cycle -> so = 1,0,1,1,0,0,1,1 on consecutive cycles; busy=1 for 8 cycles; done=1 for exactly one cycle after the last bit.
- LSB-first frame: MSB_FIRST=0, in=8'b10110011 -> so = 1,1,0,0,1,1,0,1; done pulse after the 8th bit.
- Rejected load:
  - Start a frame with in=8'b11100101.
  - Three edges later, set in=8'hFF with L=1 for one cycle.
  - Required: lost=1 for one cycle; so continues 1,1,1,0,0,1,0,1 unchanged; no 8'hFF frame follows unless L is reasserted in IDLE.
- L held high continuously with in=8'hA5: frames repeat every 9 cycles; so = 1,0,1,0,0,1,0,1 each frame; lost=1 during every busy cycle; done pulses once per frame.
- Reset mid-frame: R=1 after 4 bits of 8'b10110011 -> next cycle so=0, busy=0, done=0; a fresh L then restarts from the first bit (1).
